dir_ctrl: RTL and testbench
===========================

DIR_CTRL -- requirements
Module: dir_ctrl

Interface
REQ-001 Parameter REV_W, default 8: width of the direction-reversal counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 clear  input  1  asynchronous, active-low reset.
REQ-004 q_in  input  3  count value from the downstream 3-bit up/down counter, sampled on each rising edge of clk.
REQ-005 mode_sel  input  2  direction policy: 00 MANUAL, 01 BOUNCE, 10 FORCE_UP, 11 FORCE_DOWN.
REQ-006 man_dir  input  1  requested direction in MANUAL: 1 up, 0 down.
REQ-007 M  output  1  registered direction to the counter: 1 up, 0 down.
REQ-008 dir_chg  output  1  one-cycle pulse, asserted in the cycle after M changes value.
REQ-009 seq_err  output  1  sticky flag: q_in broke the expected sequence.
REQ-010 rev_cnt  output  REV_W  count of direction reversals.

Function
REQ-011 The FSM SHALL have exactly two states: S_UP (M=1) and S_DOWN (M=0); M SHALL be driven directly from the state register.
REQ-012 FORCE_UP: next state SHALL be S_UP. FORCE_DOWN: next state SHALL be S_DOWN. MANUAL: next state SHALL be S_UP if man_dir=1, else S_DOWN.
REQ-013 BOUNCE, lookahead rule: S_UP with q_in=6 SHALL go to S_DOWN; S_DOWN with q_in=1 SHALL go to S_UP; otherwise the state SHALL hold.
REQ-014 BOUNCE result: the counter runs ...5,6,7,6,5,...,1,0,1,2... and never wraps 7->0 or 0->7.
REQ-015 BOUNCE entered from any q_in: there is no wrap guard on the first step. The lookahead rule applies from the first sampled edge.
REQ-016 A mode_sel change SHALL take effect on the next rising edge; no intermediate state.
REQ-017 dir_chg SHALL be 1 for exactly the one cycle following any edge where the state changed.
REQ-018 rev_cnt SHALL increment by 1 on every state change and wrap at 2^REV_W-1 -> 0.
REQ-019 Sequence check: the block SHALL hold q_prev, M_prev and a valid bit. valid=0 after reset and SHALL set on the first edge.
REQ-020 When valid=1, expected q_in = q_prev+1 mod 8 if M_prev=1, else q_prev-1 mod 8.
REQ-021 Any mismatch between expected and actual q_in SHALL set seq_err on that edge.
REQ-022 seq_err SHALL remain set until clear is asserted.
REQ-023 The sequence check SHALL NOT flag the first sample after reset.
REQ-024 The sequence check SHALL NOT alter M.

Reset
REQ-025 While clear=0: state=S_UP, M=1, dir_chg=0, seq_err=0, rev_cnt=0, valid=0, q_prev=0.
REQ-026 clear asserted mid-operation SHALL force these values immediately, independent of clk.
REQ-027 Deassertion SHALL take effect at the next rising edge; the first post-reset edge SHALL be treated as first sample.

Configuration
REQ-028 Macro DIR_CTRL_REVCNT_EN defined: rev_cnt counter SHALL be instantiated per REQ-018.
REQ-029 DIR_CTRL_REVCNT_EN undefined: rev_cnt SHALL be tied to 0, with no counter flops; all other behaviour SHALL be unchanged.

Structure
REQ-030 Package dir_ctrl_pkg SHALL hold the mode_sel encodings (MODE_MANUAL, MODE_BOUNCE, MODE_FORCE_UP, MODE_FORCE_DOWN), the state encodings S_UP/S_DOWN, and the bounce turn points TURN_HI=6 and TURN_LO=1.
REQ-031 The sequence check SHALL be the sub-module dir_seq_chk (inputs clk, clear, q_in, M; output seq_err). The FSM and rev_cnt SHALL stay in dir_ctrl.

Verification
REQ-032 Reset release, mode 10, q_in incrementing 0..7,0 -> M=1 throughout; dir_chg=0; seq_err=0.
REQ-033 Mode 01, start S_UP at q_in=4, model counter from M -> q_in sequence 4,5,6,7,6,5,4,3,2,1,0,1,2; dir_chg pulses twice; rev_cnt=2 with macro defined, 0 without.
REQ-034 Mode 00, toggle man_dir 1->0->1 on three consecutive edges -> M follows one edge later each time; rev_cnt increments by 1 per toggle.
REQ-035 Mode 10 with q_in driven 2,3,5 -> seq_err rises on the edge sampling 5 and stays 1 while q_in returns to a legal sequence.
REQ-036 Assert clear mid-bounce (state S_DOWN, rev_cnt=3) between edges -> M=1, rev_cnt=0 and seq_err=0 at once; the first post-release sample of arbitrary q_in (e.g. 6) raises no seq_err.

Source files
------------

// File: rtl/dir_ctrl_pkg.sv
// Shared encodings and next-direction helpers for the direction controller.
package dir_ctrl_pkg;

  // mode_sel encodings
  localparam logic [1:0] MODE_MANUAL     = 2'b00;
  localparam logic [1:0] MODE_BOUNCE     = 2'b01;
  localparam logic [1:0] MODE_FORCE_UP   = 2'b10;
  localparam logic [1:0] MODE_FORCE_DOWN = 2'b11;

  // State encodings; the state bit is the counter direction itself (1 = up).
  localparam logic S_UP   = 1'b1;
  localparam logic S_DOWN = 1'b0;

  // Bounce turn points: turn one count early so the counter never wraps.
  localparam logic [2:0] TURN_HI = 3'd6;
  localparam logic [2:0] TURN_LO = 3'd1;

  // Next direction state for a given policy, current state and sampled count.
  function automatic logic next_state(input logic [1:0] mode,
                                      input logic       state,
                                      input logic [2:0] q,
                                      input logic       man);
    logic nxt;
    nxt = state;
    case (mode)
      MODE_MANUAL:     nxt = man ? S_UP : S_DOWN;
      MODE_BOUNCE: begin
        if ((state == S_UP) && (q == TURN_HI)) begin
          nxt = S_DOWN;
        end else if ((state == S_DOWN) && (q == TURN_LO)) begin
          nxt = S_UP;
        end else begin
          nxt = state;
        end
      end
      MODE_FORCE_UP:   nxt = S_UP;
      MODE_FORCE_DOWN: nxt = S_DOWN;
      default:         nxt = state;
    endcase
    return nxt;
  endfunction

  // Count the downstream counter must present one edge after q_prev,
  // given the direction it was told to move in.
  function automatic logic [2:0] expect_q(input logic [2:0] q_prev, input logic m_prev);
    return m_prev ? (q_prev + 3'd1) : (q_prev - 3'd1);
  endfunction

endpackage

// File: rtl/dir_seq_chk.sv
// Sequence checker: flags (sticky) any sampled count that does not follow
// from the previous sample and the direction that was in force at that edge.
// The first sample after reset only seeds the history.
module dir_seq_chk
  import dir_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic [2:0] q_in,
  input  logic       M,
  output logic       seq_err
);

  logic [2:0] r_q_prev;
  logic       r_m_prev;
  logic       r_valid;
  logic       r_seq_err;
  logic [2:0] w_q_exp;
  logic       w_mismatch;

  // Expected count and mismatch against the live sample
  always_comb begin
    w_q_exp    = expect_q(r_q_prev, r_m_prev);
    w_mismatch = r_valid && (q_in != w_q_exp);
  end

  // History capture and sticky error flag
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_q_prev  <= 3'd0;
      r_m_prev  <= S_UP;
      r_valid   <= 1'b0;
      r_seq_err <= 1'b0;
    end else begin
      r_q_prev <= q_in;
      r_m_prev <= M;
      r_valid  <= 1'b1;
      if (w_mismatch) begin
        r_seq_err <= 1'b1;
      end
    end
  end

  assign seq_err = r_seq_err;

endmodule

// File: rtl/dir_ctrl.sv
// Direction controller for a 3-bit up/down counter: two-state FSM whose
// state bit drives M, a change pulse, a reversal counter and a sequence check.
// Optional feature: define DIR_CTRL_REVCNT_EN to build the reversal counter;
// otherwise rev_cnt is tied to zero and no counter flops exist.
module dir_ctrl
  import dir_ctrl_pkg::*;
#(
  parameter int unsigned REV_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [2:0]       q_in,
  input  logic [1:0]       mode_sel,
  input  logic             man_dir,
  output logic             M,
  output logic             dir_chg,
  output logic             seq_err,
  output logic [REV_W-1:0] rev_cnt
);

  logic r_state;
  logic r_dir_chg;
  logic w_state_d;
  logic w_state_chg;

  // Next state from the selected policy; mode changes apply on the next edge
  always_comb begin
    w_state_d   = next_state(mode_sel, r_state, q_in, man_dir);
    w_state_chg = (w_state_d != r_state);
  end

  // State register and one-cycle change pulse
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state   <= S_UP;
      r_dir_chg <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_dir_chg <= w_state_chg;
    end
  end

  assign M       = r_state;
  assign dir_chg = r_dir_chg;

`ifdef DIR_CTRL_REVCNT_EN
  logic [REV_W-1:0] r_rev_cnt;

  // Reversal counter, wraps naturally at all-ones
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_rev_cnt <= '0;
    end else if (w_state_chg) begin
      r_rev_cnt <= r_rev_cnt + 1'b1;
    end
  end

  assign rev_cnt = r_rev_cnt;
`else
  assign rev_cnt = '0;
`endif

  dir_seq_chk u_seq_chk (
    .clk     (clk),
    .clear   (clear),
    .q_in    (q_in),
    .M       (r_state),
    .seq_err (seq_err)
  );

endmodule

// File: tb/tb_dir_ctrl.sv
// Bench for dir_ctrl: behavioural model checked every cycle plus directed
// scenarios with literal expectations.
module tb_dir_ctrl;

`ifdef DIR_CTRL_REVCNT_EN
  localparam bit RevEn = 1'b1;
`else
  localparam bit RevEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clear;
  logic [2:0] q_in;
  logic [1:0] mode_sel;
  logic       man_dir;
  logic       M;
  logic       dir_chg;
  logic       seq_err;
  logic [7:0] rev_cnt;

  int checks   = 0;
  int failures = 0;

  dir_ctrl #(.REV_W(8)) dut (
    .clk      (clk),
    .clear    (clear),
    .q_in     (q_in),
    .mode_sel (mode_sel),
    .man_dir  (man_dir),
    .M        (M),
    .dir_chg  (dir_chg),
    .seq_err  (seq_err),
    .rev_cnt  (rev_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev_exp(input int n);
    return RevEn ? 8'(n) : 8'd0;
  endfunction

  // ---------------- behavioural model ----------------
  bit       m_up    = 1'b1;   // direction the counter is being told
  bit       m_pulse = 1'b0;
  bit       m_err   = 1'b0;
  int       m_revs  = 0;
  bit       m_seen  = 1'b0;   // a sample exists since reset
  int       m_last_q = 0;
  bit       m_last_up = 1'b1;

  task automatic model_reset();
    m_up = 1'b1; m_pulse = 1'b0; m_err = 1'b0; m_revs = 0; m_seen = 1'b0;
    m_last_q = 0; m_last_up = 1'b1;
  endtask

  always @(negedge clear) model_reset();

  always @(posedge clk) begin
    bit want_up;
    if (!clear) begin
      model_reset();
    end else begin
      // Direction wanted after this edge
      if (mode_sel == 2'd2) want_up = 1'b1;
      else if (mode_sel == 2'd3) want_up = 1'b0;
      else if (mode_sel == 2'd0) want_up = man_dir;
      else if (m_up && int'(q_in) == 6) want_up = 1'b0;
      else if (!m_up && int'(q_in) == 1) want_up = 1'b1;
      else want_up = m_up;
      // Counter must step by one in the direction told at the previous edge
      if (m_seen && int'(q_in) != (m_last_q + (m_last_up ? 1 : 7)) % 8) m_err = 1'b1;
      m_seen    = 1'b1;
      m_last_q  = int'(q_in);
      m_last_up = m_up;
      m_pulse   = (want_up != m_up);
      if (m_pulse) m_revs = m_revs + 1;
      m_up = want_up;
    end
  end

  // Compare process: every cycle, shortly after the active edge
  always @(posedge clk) begin
    #2;
    check("model_M", 32'(M), 32'(m_up));
    check("model_dir_chg", 32'(dir_chg), 32'(m_pulse));
    check("model_seq_err", 32'(seq_err), 32'(m_err));
    check("model_rev_cnt", 32'(rev_cnt), 32'(rev_exp(m_revs % 256)));
  end

  // ---------------- stimulus ----------------
  // Advance the downstream counter model by one edge using the current M
  task automatic cnt_step();
    logic up;
    up = M;
    @(posedge clk);
    @(negedge clk);
    q_in = up ? (q_in + 3'd1) : (q_in - 3'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    clear = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] seq_exp [13];
    logic [2:0] seq_got [13];
    int pulses;
    seq_exp = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};

    clear = 1'b0; mode_sel = 2'b10; man_dir = 1'b1; q_in = 3'd0;
    repeat (2) @(negedge clk);
    check("reset_M", 32'(M), 32'd1);
    check("reset_dir_chg", 32'(dir_chg), 32'd0);
    check("reset_seq_err", 32'(seq_err), 32'd0);
    check("reset_rev_cnt", 32'(rev_cnt), 32'd0);

    // FORCE_UP with a clean incrementing count
    clear = 1'b1;
    for (int i = 0; i < 9; i++) begin
      q_in = 3'(i % 8);
      tick();
      check("fup_M", 32'(M), 32'd1);
      check("fup_dir_chg", 32'(dir_chg), 32'd0);
      check("fup_seq_err", 32'(seq_err), 32'd0);
    end

    // BOUNCE from 4 going up
    do_reset();
    mode_sel = 2'b01; q_in = 3'd4; pulses = 0;
    for (int i = 0; i < 13; i++) begin
      seq_got[i] = q_in;
      cnt_step();
      if (dir_chg) pulses++;
    end
    for (int i = 0; i < 13; i++) check("bounce_seq", 32'(seq_got[i]), 32'(seq_exp[i]));
    check("bounce_pulses", 32'(pulses), 32'd2);
    check("bounce_rev_cnt", 32'(rev_cnt), 32'(rev_exp(2)));
    check("bounce_seq_err", 32'(seq_err), 32'd0);

    // Continue up through 6 so the block is heading down with three reversals
    repeat (4) cnt_step();
    check("mid_M_down", 32'(M), 32'd0);
    check("mid_rev_cnt", 32'(rev_cnt), 32'(rev_exp(3)));
    #2 clear = 1'b0;
    #1;
    check("async_M", 32'(M), 32'd1);
    check("async_rev_cnt", 32'(rev_cnt), 32'd0);
    check("async_seq_err", 32'(seq_err), 32'd0);
    check("async_dir_chg", 32'(dir_chg), 32'd0);
    @(negedge clk);
    clear = 1'b1; q_in = 3'd6;
    cnt_step();
    check("post_rel_seq_err", 32'(seq_err), 32'd0);
    check("post_rel_M", 32'(M), 32'd0);
    repeat (3) cnt_step();

    // MANUAL toggles
    do_reset();
    mode_sel = 2'b00; man_dir = 1'b1; q_in = 3'd0;
    cnt_step();
    check("man_M_1", 32'(M), 32'd1);
    man_dir = 1'b0;
    cnt_step();
    check("man_M_0", 32'(M), 32'd0);
    check("man_chg_0", 32'(dir_chg), 32'd1);
    check("man_rev_1", 32'(rev_cnt), 32'(rev_exp(1)));
    man_dir = 1'b1;
    cnt_step();
    check("man_M_1b", 32'(M), 32'd1);
    check("man_rev_2", 32'(rev_cnt), 32'(rev_exp(2)));
    check("man_seq_err", 32'(seq_err), 32'd0);

    // Broken sequence under FORCE_UP
    do_reset();
    mode_sel = 2'b10;
    q_in = 3'd2; tick(); check("seq_2", 32'(seq_err), 32'd0);
    q_in = 3'd3; tick(); check("seq_3", 32'(seq_err), 32'd0);
    q_in = 3'd5; tick(); check("seq_5", 32'(seq_err), 32'd1);
    q_in = 3'd6; tick(); check("seq_6", 32'(seq_err), 32'd1);
    q_in = 3'd7; tick(); check("seq_7", 32'(seq_err), 32'd1);
    check("seq_M", 32'(M), 32'd1);

    // FORCE_DOWN with a clean decrementing count
    mode_sel = 2'b11;
    repeat (4) cnt_step();
    check("fdown_M", 32'(M), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
